// File: rtl/framebuffer_stream_fifo.sv
// Elastic RGB565 pixel FIFO with start threshold and line-block framing check.
// Define FB_FIFO_TLAST_REGEN_EN to store a regenerated tlast instead of the input one.
module framebuffer_stream_fifo #(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 6,
  parameter int PIXEL           = 15360,
  parameter int START_THRESHOLD = 32
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [ADDR_W:0]   fill_level,
  output logic              tlast_error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 14;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXEL - 1);
  localparam logic [ADDR_W:0] THRESH = (ADDR_W+1)'(START_THRESHOLD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DATA_W:0]     mem [DEPTH];
  logic [ADDR_W:0]     wr_ptr, rd_ptr;
  logic [ADDR_W:0]     wr_ptr_n, rd_ptr_n;
  logic [ADDR_W:0]     fill_q;
  logic [ADDR_W:0]     tl_cnt;
  logic [CNT_W-1:0]    pix_cnt;
  logic                s_ready_q;
  logic                m_valid_q;
  logic                m_last_q;
  logic [DATA_W-1:0]   m_data_q;
  logic                err_q;
  logic                push, pop;
  logic                at_last, tl_store, tl_err;
  logic                full_n, avail_n;

  assign push    = s_axis_tvalid & s_ready_q;
  assign pop     = m_axis_tvalid & m_axis_tready;
  assign at_last = pix_cnt == LAST_PIX;

`ifdef FB_FIFO_TLAST_REGEN_EN
  assign tl_store = at_last;
  assign tl_err   = s_axis_tlast != at_last;
`else
  assign tl_store = s_axis_tlast;
  assign tl_err   = (s_axis_tlast & ~at_last)
                  | (~s_axis_tlast & at_last);
`endif

  assign wr_ptr_n = wr_ptr + (ADDR_W+1)'(push);
  assign rd_ptr_n = rd_ptr + (ADDR_W+1)'(pop);

  assign full_n =
    (wr_ptr_n[ADDR_W] != rd_ptr_n[ADDR_W]) &&
    (wr_ptr_n[ADDR_W-1:0] == rd_ptr_n[ADDR_W-1:0]);

  // a word written this cycle is not yet readable from the RAM
  assign avail_n = wr_ptr != rd_ptr_n;

  always_ff @(posedge aclk) begin
    if (push)
      mem[wr_ptr[ADDR_W-1:0]] <= {tl_store, s_axis_tdata};
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_q    <= '0;
      tl_cnt    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      fill_q    <= wr_ptr_n - rd_ptr_n;
      tl_cnt    <= tl_cnt
                 + (ADDR_W+1)'(push & tl_store)
                 - (ADDR_W+1)'(pop & m_last_q);
      s_ready_q <= ~full_n;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      pix_cnt <= '0;
      err_q   <= 1'b0;
    end else if (push) begin
      if (tl_store || at_last)
        pix_cnt <= '0;
      else
        pix_cnt <= pix_cnt + CNT_W'(1);
      if (tl_err)
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (!(m_axis_tvalid && !m_axis_tready)) begin
      m_valid_q <= (state_n == STREAM) && avail_n;
      {m_last_q, m_data_q} <= mem[rd_ptr_n[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge aclk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (push || wr_ptr != rd_ptr)
          state_n = PRIME;
      PRIME:
        if (fill_q >= THRESH || tl_cnt != '0)
          state_n = STREAM;
      STREAM:
        if (pop && m_last_q)
          state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = s_ready_q;
    m_axis_tvalid = m_valid_q && (state == STREAM);
    m_axis_tlast  = m_last_q;
    m_axis_tdata  = m_data_q;
    fill_level    = fill_q;
    tlast_error   = err_q;
  end

endmodule

// File: tb/tb_framebuffer_stream_fifo.sv
// Directed/random bench for framebuffer_stream_fifo.
// Reference is a word queue plus a line-block pixel index model.
module tb_framebuffer_stream_fifo;

  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int PIX   = 15360;
  localparam int TH    = 32;
  localparam int DEPTH = 64;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [AW:0]   fill_level;
  logic          tlast_error;

  framebuffer_stream_fifo #(
    .DATA_W(DW), .ADDR_W(AW), .PIXEL(PIX), .START_THRESHOLD(TH)
  ) dut (
    .aclk(aclk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
    .fill_level(fill_level), .tlast_error(tlast_error)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  logic [DW:0]   q[$];
  int            mcnt = 0;
  logic          merr = 1'b0;
  int            pushed = 0;
  int            popped = 0;
  int            tl_out = 0;
  int            tl_idx = -1;
  logic [DW-1:0] dnext = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mcnt = 0;
    merr = 1'b0;
    pushed = 0;
    popped = 0;
    tl_out = 0;
    tl_idx = -1;
  endtask

  task automatic step(input logic sv, input logic tl, input logic mr);
    logic        push_, pop_, last, stl;
    logic [DW:0] w;
    @(negedge aclk);
    s_axis_tvalid = sv;
    s_axis_tlast  = tl;
    s_axis_tdata  = dnext;
    m_axis_tready = mr;
    push_ = sv && s_axis_tready;
    pop_  = m_axis_tvalid && mr;
    if (pop_) begin
      if (q.size() == 0) begin
        chk("valid_on_empty", m_axis_tvalid, 0);
      end else begin
        w = q.pop_front();
        chk("data", m_axis_tdata, w[DW-1:0]);
        chk("tlast", m_axis_tlast, w[DW]);
        if (m_axis_tlast) begin
          tl_out++;
          tl_idx = popped;
        end
        popped++;
      end
    end
    if (push_) begin
      last = (mcnt == PIX - 1);
`ifdef FB_FIFO_TLAST_REGEN_EN
      stl = last;
      if (tl != last) merr = 1'b1;
`else
      stl = tl;
      if (tl && !last) merr = 1'b1;
      if (!tl && last) merr = 1'b1;
`endif
      q.push_back({stl, dnext});
      mcnt = (stl || last) ? 0 : mcnt + 1;
      dnext++;
      pushed++;
    end
    @(posedge aclk);
    #1;
    chk("fill", fill_level, q.size());
    chk("s_ready", s_axis_tready, q.size() < DEPTH);
    chk("err", tlast_error, merr);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    if (q.size() != 0)
      chk("drain_timeout", fill_level, 0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("valid_after_drain", m_axis_tvalid, 0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_ready", s_axis_tready, 0);
    chk("rst_valid", m_axis_tvalid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_err", tlast_error, 0);
    reset = 1'b0;
    model_clear();
    @(posedge aclk);
    #1;
    chk("rst_ready_after", s_axis_tready, 1);
    chk("rst_fill_after", fill_level, 0);
  endtask

  initial begin
    int n, p0, guard;

    // T1 reset
    do_reset();

    // T2 threshold
    for (int i = 0; i < TH - 1; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("t2_hold", m_axis_tvalid, 0);
    end
    repeat (3) begin
      step(1'b0, 1'b0, 1'b1);
      chk("t2_prime", m_axis_tvalid, 0);
    end
    step(1'b1, 1'b0, 1'b1);
    n = 0;
    while (!m_axis_tvalid && n < 2) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("t2_start", m_axis_tvalid, 1);
    chk("t2_first", m_axis_tdata, 0);
    drain(200);
    chk("t2_count", popped, TH);

    // T3 full / backpressure
    for (int i = 0; i < 70; i++)
      step(1'b1, 1'b0, 1'b0);
    chk("t3_fill", fill_level, DEPTH);
    chk("t3_ready", s_axis_tready, 0);
    p0 = popped;
    drain(300);
    chk("t3_out", popped - p0, DEPTH);

    // T4 simultaneous read+write
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t4_fill0", fill_level, 40);
    p0 = popped;
    for (int i = 0; i < 100; i++)
      step(1'b1, 1'b0, 1'b1);
    chk("t4_fill", fill_level, 40);
    chk("t4_pops", popped - p0, 100);
    drain(300);

    // T5 full line-block with random stalls
    do_reset();
    guard = 0;
    while (pushed < PIX && guard < 60000) begin
      step($urandom_range(3) != 0, pushed == PIX - 1, $urandom_range(3) != 0);
      guard++;
    end
    chk("t5_sent", pushed, PIX);
    drain(500);
    chk("t5_tl_count", tl_out, 1);
    chk("t5_tl_idx", tl_idx, PIX - 1);
    chk("t5_err", tlast_error, 0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b1);
    repeat (4) begin
      step(1'b0, 1'b0, 1'b1);
      chk("t5_idle", m_axis_tvalid, 0);
    end

    // T6 early tlast
    do_reset();
    while (pushed < 101) begin
      step(1'b1, pushed == 100, 1'b1);
    end
    drain(300);
    chk("t6_err", tlast_error, 1);
`ifdef FB_FIFO_TLAST_REGEN_EN
    chk("t6_tl_none", tl_out, 0);
`else
    chk("t6_tl_count", tl_out, 1);
    chk("t6_tl_idx", tl_idx, 100);
`endif
    repeat (10) step(1'b0, 1'b0, 1'b1);
    chk("t6_sticky", tlast_error, 1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
